// File: rtl/bcd_pkg.sv
// Shared types and constants for the packed-BCD arithmetic stages.
// No timing or flow control; definitions only.
package bcd_pkg;

  localparam int DIGIT_W = 4;
  localparam int BCD_MAX = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mul5bcd.sv
// Combinational BCD digit times 5, split into tens and units digits.
// Zero latency; no flow control. Undefined for digit > 9 (caller must flag it).
module mul5bcd
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] d_i,
  output logic [DIGIT_W-1:0] tens_o,
  output logic [DIGIT_W-1:0] units_o
);

  // d*5 = (d/2)*10 + (d odd ? 5 : 0), so tens is a shift and units is 0 or 5.
  assign tens_o  = {1'b0, d_i[DIGIT_W-1:1]};
  assign units_o = d_i[0] ? 4'd5 : 4'd0;

endmodule

// File: rtl/bcd_mul5_seq.sv
// Multiplies an N-digit packed-BCD operand by 5, one digit per clk, LSD first.
// start to done takes N+1 cycles; start is ignored (not queued) unless IDLE.
module bcd_mul5_seq
  import bcd_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [DIGIT_W*N-1:0]   num,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [DIGIT_W*(N+1)-1:0] result
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  state_t                     state_q, state_d;
  logic [DIGIT_W*N-1:0]       opnd_q, opnd_d;
  logic [DIGIT_W-1:0]         carry_q, carry_d;
  logic [IW-1:0]              idx_q, idx_d;
  logic [DIGIT_W*(N+1)-1:0]   result_q, result_d;
  logic                       err_q, err_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;

  logic [DIGIT_W-1:0]         cur_digit;
  logic [DIGIT_W-1:0]         cur_tens;
  logic [DIGIT_W-1:0]         cur_units;

  assign cur_digit = opnd_q[DIGIT_W-1:0];

  mul5bcd u_mul5bcd (
    .d_i     (cur_digit),
    .tens_o  (cur_tens),
    .units_o (cur_units)
  );

  always_comb begin
    state_d  = state_q;
    opnd_d   = opnd_q;
    carry_d  = carry_q;
    idx_d    = idx_q;
    result_d = result_q;
    err_d    = err_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          opnd_d   = num;
          carry_d  = '0;
          idx_d    = '0;
          result_d = '0;
          err_d    = 1'b0;
          busy_d   = 1'b1;
          state_d  = RUN;
        end
      end

      RUN: begin
        busy_d = 1'b1;
        if (cur_digit > DIGIT_W'(BCD_MAX)) begin
          err_d    = 1'b1;
          result_d = '0;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          state_d  = DONE;
        end else begin
          // units is 0 or 5 and carry is at most 4, so the sum never needs correction.
          result_d[idx_q*DIGIT_W +: DIGIT_W] = cur_units + carry_q;
          carry_d = cur_tens;
          opnd_d  = opnd_q >> DIGIT_W;
          idx_d   = idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            result_d[N*DIGIT_W +: DIGIT_W] = cur_tens;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      opnd_q   <= '0;
      carry_q  <= '0;
      idx_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      opnd_q   <= opnd_d;
      carry_q  <= carry_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;
  assign result = result_q;

endmodule

// File: tb/tb_bcd_mul5_seq.sv
// Directed bench for bcd_mul5_seq at N=4 and N=1; expectations are queued at
// start time and checked by a monitor whenever done is seen.
module tb_bcd_mul5_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start4, start1;
  logic [15:0] num4;
  logic [3:0]  num1;
  logic        busy4, done4, err4;
  logic [19:0] result4;
  logic        busy1, done1, err1;
  logic [7:0]  result1;

  always #5 clk = ~clk;

  bcd_mul5_seq #(.N(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .num(num4),
    .busy(busy4), .done(done4), .err(err4), .result(result4)
  );

  bcd_mul5_seq #(.N(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .num(num1),
    .busy(busy1), .done(done1), .err(err1), .result(result1)
  );

  typedef struct {
    logic        err;
    logic [19:0] res;
    int          cyc;
  } exp_t;

  exp_t q4[$];
  exp_t q1[$];
  exp_t e4, e1;
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;

  // Hand-computed d*5 as two BCD digits.
  logic [7:0] tbl [10] = '{8'h00, 8'h05, 8'h10, 8'h15, 8'h20,
                           8'h25, 8'h30, 8'h35, 8'h40, 8'h45};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (done4 === 1'b1) begin
      if (q4.size() == 0) begin
        chk("spurious_done4", 32'(done4), 32'd0);
      end else begin
        e4 = q4.pop_front();
        chk("result4", 32'(result4), 32'(e4.res));
        chk("err4", 32'(err4), 32'(e4.err));
        chk("done_cycle4", cyc, e4.cyc);
      end
    end
    if (done1 === 1'b1) begin
      if (q1.size() == 0) begin
        chk("spurious_done1", 32'(done1), 32'd0);
      end else begin
        e1 = q1.pop_front();
        chk("result1", 32'(result1), 32'(e1.res[7:0]));
        chk("err1", 32'(err1), 32'(e1.err));
        chk("done_cycle1", cyc, e1.cyc);
      end
    end
  end

  task automatic go4(input logic [15:0] n, input logic e, input logic [19:0] r,
                     input int lat, input int busy_exp);
    int nb;
    nb = 0;
    start4 = 1'b1;
    num4   = n;
    q4.push_back('{e, r, cyc + lat});
    @(negedge clk);
    start4 = 1'b0;
    for (int i = 0; i < 30 && q4.size() != 0; i++) begin
      if (busy4 === 1'b1) nb++;
      @(negedge clk);
    end
    chk("timeout4", q4.size(), 32'd0);
    q4.delete();
    @(negedge clk);
    chk("busy_cycles4", nb, busy_exp);
  endtask

  task automatic go1(input logic [3:0] n, input logic e, input logic [7:0] r);
    start1 = 1'b1;
    num1   = n;
    q1.push_back('{e, {12'h0, r}, cyc + 2});
    @(negedge clk);
    start1 = 1'b0;
    for (int i = 0; i < 10 && q1.size() != 0; i++) @(negedge clk);
    chk("timeout1", q1.size(), 32'd0);
    q1.delete();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst    = 1'b1;
    start4 = 1'b0;
    start1 = 1'b0;
    num4   = '0;
    num1   = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy4), 32'd0);
    chk("rst_done", 32'(done4), 32'd0);
    chk("rst_err", 32'(err4), 32'd0);
    chk("rst_result", 32'(result4), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    go4(16'h1234, 1'b0, 20'h06170, 5, 4);
    go4(16'h9999, 1'b0, 20'h49995, 5, 4);
    go4(16'h0000, 1'b0, 20'h00000, 5, 4);
    go4(16'h12A4, 1'b1, 20'h00000, 3, 2);
    chk("err_held", 32'(err4), 32'd1);
    go4(16'h0002, 1'b0, 20'h00010, 5, 4);
    chk("result_held", 32'(result4), 32'h00010);

    // start held high: one op per IDLE visit, num changes mid-run ignored.
    begin
      int k;
      k = cyc;
      start4 = 1'b1;
      num4   = 16'h1234;
      q4.push_back('{1'b0, 20'h06170, k + 5});
      q4.push_back('{1'b0, 20'h06170, k + 11});
      repeat (2) @(negedge clk);
      num4 = 16'h9999;
      repeat (3) @(negedge clk);
      num4 = 16'h1234;
      repeat (2) @(negedge clk);
      start4 = 1'b0;
      @(negedge clk);
      num4 = 16'h0000;
      for (int i = 0; i < 30 && q4.size() != 0; i++) @(negedge clk);
      chk("timeout_hold", q4.size(), 32'd0);
      q4.delete();
      repeat (3) @(negedge clk);
      chk("no_third_op", 32'(busy4), 32'd0);
    end

    // Reset during RUN at c+2 aborts with no done pulse.
    start4 = 1'b1;
    num4   = 16'h9999;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(busy4), 32'd0);
    chk("abort_done", 32'(done4), 32'd0);
    chk("abort_result", 32'(result4), 32'd0);
    chk("abort_err", 32'(err4), 32'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("abort_idle", 32'(busy4), 32'd0);

    for (int d = 0; d < 10; d++) go1(4'(d), 1'b0, tbl[d]);
    for (int d = 10; d < 16; d++) go1(4'(d), 1'b1, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
